// File: rtl/bsg_counter_slot_arbiter_pkg.sv
// Shared typedefs and helpers for the counter-slot arbiter.
//   bsg_slot_state_e : arbiter FSM state (IDLE / BUSY)
//   bsg_id_width()   : requester-index width derived from the requester count
package bsg_counter_slot_arbiter_pkg;

  typedef enum logic [0:0] {
    eIdle = 1'b0,
    eBusy = 1'b1
  } bsg_slot_state_e;

  // Keeps the index at least one bit wide even for a single requester.
  function automatic int bsg_id_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_counter_slot_timer.sv
// Slot timer: counts grant cycles of the current slot against a length
// captured at load time.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : drop count and captured length to zero
//   load_i         : start a slot (count=1) and capture len_i
//   en_i           : advance the count by one
//   len_i          : slot length to capture on load
//   term_o         : count equals captured length (final cycle of slot)
module bsg_counter_slot_timer #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [width_p-1:0] len_i,
  output logic               term_o
);

  logic [width_p-1:0] cnt_r;
  logic [width_p-1:0] len_r;

  // The owner never enables counting in a cycle where term_o is high, so a
  // max-length slot stops at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_r <= '0;
      len_r <= '0;
    end else if (load_i) begin
      cnt_r <= width_p'(1);
      len_r <= len_i;
    end else if (en_i) begin
      cnt_r <= cnt_r + width_p'(1);
    end
  end

  assign term_o = (cnt_r == len_r);

endmodule

// File: rtl/bsg_counter_slot_arbiter.sv
// Round-robin arbiter granting each requester a time slot of programmable
// length. A slot ends on length exhaustion or when the holder drops its
// request; the next grant follows back-to-back when anyone is eligible.
//   clk_i, reset_i : clock, synchronous active-high reset
//   reqs_i         : per-requester request levels
//   cfg_v_i        : write strobe for per-requester slot length
//   cfg_id_i       : requester written (out-of-range ids are dropped)
//   cfg_len_i      : new slot length, 0 disables the requester
//   grant_o        : registered one-hot grant, zero when idle
//   grant_id_o     : index of the holder, zero when idle
//   done_o         : final grant cycle of a slot
//   expired_o      : with done_o, slot ended by length exhaustion
module bsg_counter_slot_arbiter
  import bsg_counter_slot_arbiter_pkg::*;
#(
  parameter int els_p         = 4,
  parameter int len_width_p   = 16,
  parameter int default_len_p = 8,
  localparam int id_width_lp  = bsg_id_width(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [els_p-1:0]       reqs_i,
  input  logic                   cfg_v_i,
  input  logic [id_width_lp-1:0] cfg_id_i,
  input  logic [len_width_p-1:0] cfg_len_i,
  output logic [els_p-1:0]       grant_o,
  output logic [id_width_lp-1:0] grant_id_o,
  output logic                   done_o,
  output logic                   expired_o
);

  // Per-requester slot lengths. Ids >= els_p match no entry and are ignored.
  logic [els_p-1:0][len_width_p-1:0] len_r;
  logic [els_p-1:0]                  en_mask;
  logic [els_p-1:0]                  elig;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (reset_i)
        len_r[i] <= len_width_p'(default_len_p);
      else if (cfg_v_i && (cfg_id_i == id_width_lp'(i)))
        len_r[i] <= cfg_len_i;
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_mask
    assign en_mask[i] = |len_r[i];
  end

  assign elig = reqs_i & en_mask;

  // Round-robin pick: first eligible index scanning from last_id+1 and
  // wrapping; k = els_p lands on last_id itself so a lone holder regrants.
  logic [id_width_lp-1:0] last_id_r;
  logic [id_width_lp-1:0] pick;
  logic [id_width_lp-1:0] idx;
  logic                   found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= els_p; k++) begin
      idx = id_width_lp'((int'(last_id_r) + k) % els_p);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Slot control
  bsg_slot_state_e state_r, state_n;
  logic            t_load, t_en, t_clear, t_term;
  logic            holder_req;
  logic            final_c;

  assign holder_req = reqs_i[grant_id_o];
  assign final_c    = (state_r == eBusy) && (t_term || !holder_req);

  always_comb begin
    state_n = state_r;
    t_load  = 1'b0;
    t_en    = 1'b0;
    t_clear = 1'b0;
    case (state_r)
      eIdle: begin
        if (found) begin
          state_n = eBusy;
          t_load  = 1'b1;
        end
      end
      eBusy: begin
        if (final_c) begin
          if (found) begin
            t_load = 1'b1;
          end else begin
            state_n = eIdle;
            t_clear = 1'b1;
          end
        end else begin
          t_en = 1'b1;
        end
      end
      default: begin
        state_n = eIdle;
        t_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= eIdle;
      grant_o    <= '0;
      grant_id_o <= '0;
      last_id_r  <= id_width_lp'(els_p - 1);
    end else begin
      state_r <= state_n;
      if (t_load) begin
        grant_o    <= {{(els_p-1){1'b0}}, 1'b1} << pick;
        grant_id_o <= pick;
        last_id_r  <= pick;
      end else if (t_clear) begin
        grant_o    <= '0;
        grant_id_o <= '0;
      end
    end
  end

  // Length is sampled from the table only at grant time, so a cfg write to
  // the current holder waits for its next slot.
  bsg_counter_slot_timer #(
    .width_p(len_width_p)
  ) timer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(t_clear),
    .load_i (t_load),
    .en_i   (t_en),
    .len_i  (len_r[pick]),
    .term_o (t_term)
  );

  // A slot cut short by reset never reports completion. Release wins over
  // exhaustion when both happen in the same cycle.
  assign done_o    = final_c && !reset_i;
  assign expired_o = done_o && t_term && holder_req;

endmodule
